sram_bus_master: RTL and testbench

Bus master for the 8K×8 sector SRAM. It turns a byte-write stream from the host side and a byte-read stream from the floppy side into single-cycle SRAM accesses on the shared `data`/`addr`/`rw`/`en` interface. It owns the bidirectional data bus and handles bus turnaround. Two request ports share the SRAM through round-robin arbitration, and each port has its own auto-incrementing address pointer.

---
 rtl/sram_bus_master.sv | 143 ++++++++++++++
 tb/tb_sram_bus_master.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_bus_master.sv
// Single-master bus controller for the 8Kx8 sector SRAM: round-robin between a host
// write stream and a floppy read stream, with a turnaround cycle before a write that follows a read.
module sram_bus_master #(
   parameter int ADDR_W = 13,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   inout  wire  [DATA_W-1:0] data,
   output logic [ADDR_W-1:0] addr,
   output logic              rw,
   output logic              en,
   input  logic              wr_start,
   input  logic [ADDR_W-1:0] wr_base,
   input  logic              wr_valid,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ready,
   input  logic              rd_start,
   input  logic [ADDR_W-1:0] rd_base,
   input  logic              rd_req,
   output logic              rd_busy,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data
);

   typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_RDATA, S_TURN} state_t;

   state_t             state_q, state_d;
   logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, addr_q, addr_d;
   logic [DATA_W-1:0]  wdat_q, wdat_d, rd_data_q, rd_data_d;
   logic               rd_pend_q, rd_pend_d, last_gnt_rd_q, last_gnt_rd_d;
   logic               last_op_rd_q, last_op_rd_d, rd_valid_q, rd_valid_d;
   logic               en_q, en_d, rw_q, rw_d, drv_q, drv_d;
   logic               rd_accept, wr_cand, rd_cand;

   assign rd_busy  = rd_pend_q | (state_q == S_READ) | (state_q == S_RDATA);
   assign en       = en_q;
   assign rw       = rw_q;
   assign addr     = addr_q;
   assign rd_valid = rd_valid_q;
   assign rd_data  = rd_data_q;
   assign data     = drv_q ? wdat_q : 'z;

   always_comb begin
      state_d       = state_q;
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      wdat_d        = wdat_q;
      rd_data_d     = rd_data_q;
      rd_pend_d     = rd_pend_q;
      last_gnt_rd_d = last_gnt_rd_q;
      last_op_rd_d  = last_op_rd_q;
      rd_valid_d    = 1'b0;
      wr_ready      = 1'b0;
      // A start pulse retargets its port, so that port takes no grant in the same cycle.
      rd_accept     = rd_req & ~rd_busy & ~rd_start;
      rd_cand       = (rd_pend_q | rd_accept) & ~rd_start;
      wr_cand       = wr_valid & ~wr_start & ~rst;

      case (state_q)
         S_IDLE: begin
            if (wr_cand && (!rd_cand || last_gnt_rd_q)) begin
               if (last_op_rd_q) begin
                  state_d = S_TURN;
               end else begin
                  wr_ready      = 1'b1;
                  wdat_d        = wr_data;
                  state_d       = S_WRITE;
                  last_gnt_rd_d = 1'b0;
               end
            end else if (rd_cand) begin
               state_d       = S_READ;
               last_gnt_rd_d = 1'b1;
            end
         end
         S_WRITE: begin
            state_d  = S_IDLE;
            wr_ptr_d = wr_ptr_q + 1'b1;
         end
         S_READ: begin
            state_d      = S_RDATA;
            rd_ptr_d     = rd_ptr_q + 1'b1;
            last_op_rd_d = 1'b1;
         end
         S_RDATA: begin
            state_d    = S_IDLE;
            rd_data_d  = data;
            rd_valid_d = 1'b1;
         end
         S_TURN: begin
            state_d      = S_IDLE;
            last_op_rd_d = 1'b0;
         end
         default: state_d = S_IDLE;
      endcase

      if (wr_start) wr_ptr_d = wr_base;
      if (rd_start) rd_ptr_d = rd_base;
      if (rd_accept) rd_pend_d = 1'b1;
      if (rd_start || state_d == S_READ) rd_pend_d = 1'b0;

      // Bus pins are registered from the next state so they line up with the state they belong to.
      en_d   = (state_d == S_WRITE) || (state_d == S_READ);
      rw_d   = (state_d != S_WRITE);
      drv_d  = (state_d == S_WRITE);
      addr_d = addr_q;
      if (state_d == S_WRITE)     addr_d = wr_ptr_q;
      else if (state_d == S_READ) addr_d = rd_ptr_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         addr_q        <= '0;
         wdat_q        <= '0;
         rd_data_q     <= '0;
         rd_pend_q     <= 1'b0;
         last_gnt_rd_q <= 1'b1;
         last_op_rd_q  <= 1'b0;
         rd_valid_q    <= 1'b0;
         en_q          <= 1'b0;
         rw_q          <= 1'b1;
         drv_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         addr_q        <= addr_d;
         wdat_q        <= wdat_d;
         rd_data_q     <= rd_data_d;
         rd_pend_q     <= rd_pend_d;
         last_gnt_rd_q <= last_gnt_rd_d;
         last_op_rd_q  <= last_op_rd_d;
         rd_valid_q    <= rd_valid_d;
         en_q          <= en_d;
         rw_q          <= rw_d;
         drv_q         <= drv_d;
      end
   end

endmodule

// File: tb/tb_sram_bus_master.sv
// Bench for sram_bus_master: synchronous-read SRAM model, bus contention monitor,
// table-driven write/read-back vectors and hand-written arbitration/reset sequences.
module tb_sram_bus_master;

   logic        clk = 1'b0;
   logic        rst;
   wire  [7:0]  data;
   logic [12:0] addr;
   logic        rw, en;
   logic        wr_start, wr_valid, wr_ready;
   logic [12:0] wr_base, rd_base;
   logic [7:0]  wr_data, rd_data;
   logic        rd_start, rd_req, rd_busy, rd_valid;

   int n_tests = 0;
   int n_fail  = 0;
   int viol    = 0;
   bit started = 0;

   sram_bus_master #(.ADDR_W(13), .DATA_W(8)) dut (
      .clk(clk), .rst(rst), .data(data), .addr(addr), .rw(rw), .en(en),
      .wr_start(wr_start), .wr_base(wr_base), .wr_valid(wr_valid), .wr_data(wr_data),
      .wr_ready(wr_ready), .rd_start(rd_start), .rd_base(rd_base), .rd_req(rd_req),
      .rd_busy(rd_busy), .rd_valid(rd_valid), .rd_data(rd_data)
   );

   always #5 clk = ~clk;

   // SRAM: registered read, drives the bus in the cycle after an enabled read.
   logic [7:0] mem [0:8191];
   logic [7:0] sram_q;
   logic       sram_oe = 1'b0;
   assign data = sram_oe ? sram_q : 8'bz;

   always @(posedge clk) begin
      if (en === 1'b1 && rw === 1'b0) mem[addr] <= data;
      sram_oe <= (en === 1'b1 && rw === 1'b1);
      sram_q  <= mem[addr];
   end

   always @(negedge clk) begin
      if (started) begin
         if (!sram_oe && (!en || rw) && data !== 8'bz) viol++;
         if (sram_oe && en && !rw) viol++;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer a byte until accepted, then check the WRITE cycle on the bus. Ends inside the WRITE cycle.
   task automatic do_write(input logic [7:0] d, input logic [12:0] a);
      int n = 0;
      wr_valid = 1'b1;
      wr_data  = d;
      #1;
      while (!wr_ready && n < 12) begin
         @(posedge clk);
         #2;
         n++;
      end
      chk("wr_ready_seen", wr_ready, 1'b1);
      tick();
      wr_valid = 1'b0;
      chk("wr_en", en, 1'b1);
      chk("wr_rw", rw, 1'b0);
      chk("wr_addr", addr, a);
      chk("wr_data_bus", data, d);
   endtask

   // Must be called in IDLE with no write pending; expects rd_valid 3 cycles after rd_req.
   task automatic do_read(input logic [12:0] a, input logic [7:0] d);
      int k = 1;
      rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
      chk("rd_en", en, 1'b1);
      chk("rd_rw", rw, 1'b1);
      chk("rd_addr", addr, a);
      while (!rd_valid && k < 8) begin
         tick();
         k++;
      end
      chk("rd_latency", k, 3);
      chk("rd_data", rd_data, d);
   endtask

   typedef struct {
      logic [12:0] base;
      logic [7:0]  d0, d1;
      logic [12:0] a0, a1;
   } vec_t;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1);
   end

   initial begin
      vec_t  vt[4];
      string exp_pat;
      byte   op;
      int    cnt;

      vt[0] = '{13'h0000, 8'hFF, 8'hAA, 13'h0000, 13'h0001};
      vt[1] = '{13'h1FFF, 8'h11, 8'h22, 13'h1FFF, 13'h0000};
      vt[2] = '{13'h0800, 8'h5A, 8'hA5, 13'h0800, 13'h0801};
      vt[3] = '{13'h1234, 8'h00, 8'h7E, 13'h1234, 13'h1235};
      exp_pat = ".W.R....W.R....W.R....";

      rst = 1'b1; wr_start = 0; wr_valid = 0; wr_base = '0; wr_data = '0;
      rd_start = 0; rd_req = 0; rd_base = '0;
      tick(); tick();
      started = 1;
      chk("rst_en", en, 1'b0);
      chk("rst_rw", rw, 1'b1);
      chk("rst_addr", addr, 13'h0);
      chk("rst_data_z", data === 8'bz, 1'b1);
      chk("rst_rd_valid", rd_valid, 1'b0);
      chk("rst_rd_data", rd_data, 8'h00);
      chk("rst_wr_ready", wr_ready, 1'b0);
      chk("rst_rd_busy", rd_busy, 1'b0);
      rst = 1'b0;

      // Both ports saturated from the first cycle after reset.
      wr_valid = 1'b1;
      wr_data  = 8'h40;
      for (int c = 0; c < 22; c++) begin
         rd_req = !rd_busy;
         op = (en && !rw) ? "W" : ((en && rw) ? "R" : ".");
         chk($sformatf("arb_cyc%0d", c), op, exp_pat[c]);
         if (c == 6 || c == 13) chk($sformatf("turn_z_cyc%0d", c), data === 8'bz, 1'b1);
         tick();
      end
      wr_valid = 1'b0;
      rd_req   = 1'b0;
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;

      for (int i = 0; i < 4; i++) begin
         wr_start = 1'b1;
         wr_base  = vt[i].base;
         tick();
         wr_start = 1'b0;
         do_write(vt[i].d0, vt[i].a0);
         tick();
         do_write(vt[i].d1, vt[i].a1);
         tick();
         rd_start = 1'b1;
         rd_base  = vt[i].base;
         tick();
         rd_start = 1'b0;
         do_read(vt[i].a0, vt[i].d0);
         do_read(vt[i].a1, vt[i].d1);
         $display("[TB] vector %0d base 0x%0h done", i, vt[i].base);
      end

      // Repeated rd_req while busy yields a single byte.
      tick();
      rd_req = 1'b1;
      tick();
      rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
      cnt = 0;
      for (int j = 0; j < 8; j++) begin
         if (rd_valid) cnt++;
         tick();
      end
      chk("dup_rd_req_valids", cnt, 1);

      // wr_start coincident with wr_valid.
      wr_start = 1'b1;
      wr_base  = 13'h0ABC;
      wr_valid = 1'b1;
      wr_data  = 8'h99;
      #1;
      chk("wr_start_blocks_ready", wr_ready, 1'b0);
      tick();
      wr_start = 1'b0;
      do_write(8'h99, 13'h0ABC);
      tick();

      // Reset during WRITE.
      wr_start = 1'b1;
      wr_base  = 13'h0100;
      tick();
      wr_start = 1'b0;
      do_write(8'h5E, 13'h0100);
      tick();
      do_write(8'h77, 13'h0101);
      rst = 1'b1;
      tick();
      chk("rstw_en", en, 1'b0);
      chk("rstw_data_z", data === 8'bz, 1'b1);
      chk("rstw_rd_valid", rd_valid, 1'b0);
      rst = 1'b0;
      do_write(8'h3C, 13'h0000);
      tick();

      // Reset during READ.
      rd_start = 1'b1;
      rd_base  = 13'h0100;
      tick();
      rd_start = 1'b0;
      rd_req   = 1'b1;
      tick();
      rd_req = 1'b0;
      chk("rstr_read_addr", addr, 13'h0100);
      rst = 1'b1;
      tick();
      chk("rstr_en", en, 1'b0);
      rst = 1'b0;
      cnt = 0;
      for (int j = 0; j < 6; j++) begin
         if (rd_valid) cnt++;
         tick();
      end
      chk("rstr_no_rd_valid", cnt, 0);
      do_read(13'h0000, 8'h3C);

      tick();
      chk("bus_contention", viol, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
